reg_file_mp: RTL and testbench
==============================

REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 Parameter DATA_W, default 32, register width in bits.
REQ-002 Parameter ADDR_W, default 5, address width; DEPTH = 2**ADDR_W entries, derived and not overridable.
REQ-003 clk_i  input  1  clock, all state updates on rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-high.
REQ-005 clear_i  input  1  single-cycle request to start a synchronous sweep clear.
REQ-006 ready_o  output  1  high when IDLE and accepting writes and issues.
REQ-007 ra_addr_i, rb_addr_i  input  ADDR_W  read port A/B addresses.
REQ-008 ra_data_o, rb_data_o  output  DATA_W  read port A/B data, combinational.
REQ-009 ra_busy_o, rb_busy_o  output  1  scoreboard busy flag of the addressed entry, combinational.
REQ-010 wa_en_i, wb_en_i  input  1  write enables, ports A/B.
REQ-011 wa_addr_i, wb_addr_i  input  ADDR_W  write addresses.
REQ-012 wa_data_i, wb_data_i  input  DATA_W  write data.
REQ-013 issue_en_i  input  1  marks issue_addr_i as having a pending producer.
REQ-014 issue_addr_i  input  ADDR_W  destination being issued.

Function
REQ-015 Entry 0 SHALL always read 0, SHALL ignore writes and issues, and SHALL never report busy.
REQ-016 Reads SHALL be combinational from the storage array, with zero read latency.
REQ-017 An enabled write to a nonzero entry SHALL update the entry at the rising edge while ready_o=1.
REQ-018 Write-through bypass: a read whose address matches a same-cycle enabled nonzero write SHALL return that write data.
REQ-019 If both write ports target the same address in one cycle, port B SHALL win for storage and bypass.
REQ-020 Busy bit: issue_en_i SHALL set busy[issue_addr_i] at the edge, and an enabled write SHALL clear busy[addr] at the edge.
REQ-021 If an issue and a write target the same entry in the same cycle, busy SHALL end set, because the issue is a newer producer.
REQ-022 ra_busy_o/rb_busy_o SHALL equal the stored busy bit, forced to 0 when a same-cycle enabled write targets that address (bypass).
REQ-023 FSM states: IDLE and SWEEP; ready_o = (state==IDLE).
REQ-024 IDLE -> SWEEP on clear_i=1; the sweep index SHALL load 1.
REQ-025 Each SWEEP cycle SHALL write 0 to entry[idx], clear busy[idx], and increment idx.
REQ-026 SWEEP -> IDLE on the edge that clears idx==DEPTH-1; a sweep occupies exactly DEPTH-1 cycles; idx SHALL not wrap.
REQ-027 During SWEEP, writes, issues and clear_i SHALL be ignored; all read data and busy outputs SHALL be 0.
REQ-028 clear_i coinciding with writes/issues in IDLE: the sweep SHALL start and the same-cycle writes/issues SHALL be discarded.

Reset
REQ-029 rst_i=1 SHALL asynchronously zero all entries and busy bits, force IDLE, ready_o=1, idx=0, and all read data/busy outputs 0.
REQ-030 Reset asserted mid-sweep SHALL abort the sweep immediately; after release the block SHALL be IDLE and fully zero.
REQ-031 Release of rst_i SHALL NOT trigger a sweep.

Verification (DATA_W=32, ADDR_W=5)
REQ-032 Reset, write A r5=0x12345678 -> next cycle ra_addr=5 reads 0x12345678; write r0=0xFFFFFFFF -> r0 reads 0.
REQ-033 Same cycle wa: r7=0xAAAA0000, wb: r7=0x0000BBBB, ra_addr=7 -> ra_data_o=0x0000BBBB combinationally and after the edge.
REQ-034 Issue r9 -> rb_busy(9)=1 next cycle; write r9=0x55 plus issue r9 same cycle -> busy stays 1 with data 0x55; lone write clears busy (combinationally that cycle).
REQ-035 Fill r1..r31 nonzero, pulse clear_i -> ready_o low for exactly 31 cycles, then all reads 0, busy 0; writes during the sweep are lost.
REQ-036 Assert rst_i at sweep cycle 10 -> immediate ready_o=1 and all zero; no sweep resumes after release.

Source files
------------

// File: rtl/reg_file_mp.sv
// Multi-ported register file (2R/2W) with per-entry busy scoreboard,
// write-through bypass on both read ports and a synchronous sweep clear.
module reg_file_mp #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  output logic              ready_o,
  input  logic [ADDR_W-1:0] ra_addr_i,
  input  logic [ADDR_W-1:0] rb_addr_i,
  output logic [DATA_W-1:0] ra_data_o,
  output logic [DATA_W-1:0] rb_data_o,
  output logic              ra_busy_o,
  output logic              rb_busy_o,
  input  logic              wa_en_i,
  input  logic              wb_en_i,
  input  logic [ADDR_W-1:0] wa_addr_i,
  input  logic [ADDR_W-1:0] wb_addr_i,
  input  logic [DATA_W-1:0] wa_data_i,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic              issue_en_i,
  input  logic [ADDR_W-1:0] issue_addr_i
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;

  logic idle;
  logic wa_act, wb_act, iss_act;
  logic ra_hit_a, ra_hit_b, rb_hit_a, rb_hit_b;

  assign idle    = (state == IDLE);
  assign ready_o = idle;

  // A write or issue only takes effect in IDLE when no clear is being requested.
  assign wa_act  = idle && !clear_i && wa_en_i    && (wa_addr_i    != '0);
  assign wb_act  = idle && !clear_i && wb_en_i    && (wb_addr_i    != '0);
  assign iss_act = idle && !clear_i && issue_en_i && (issue_addr_i != '0);

  assign ra_hit_a = wa_act && (wa_addr_i == ra_addr_i);
  assign ra_hit_b = wb_act && (wb_addr_i == ra_addr_i);
  assign rb_hit_a = wa_act && (wa_addr_i == rb_addr_i);
  assign rb_hit_b = wb_act && (wb_addr_i == rb_addr_i);

  // State, storage and scoreboard; later assignments win (B over A, issue over write).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      idx   <= '0;
      busy  <= '0;
      mem   <= '{default: '0};
    end else begin
      case (state)
        IDLE: begin
          if (clear_i) begin
            state <= SWEEP;
            idx   <= ADDR_W'(1);
          end else begin
            if (wa_act) begin
              mem[wa_addr_i]  <= wa_data_i;
              busy[wa_addr_i] <= 1'b0;
            end
            if (wb_act) begin
              mem[wb_addr_i]  <= wb_data_i;
              busy[wb_addr_i] <= 1'b0;
            end
            if (iss_act) begin
              busy[issue_addr_i] <= 1'b1;
            end
          end
        end
        SWEEP: begin
          mem[idx]  <= '0;
          busy[idx] <= 1'b0;
          // Last entry done: return to IDLE with the index parked at 0.
          if (idx == ADDR_W'(DEPTH - 1)) begin
            state <= IDLE;
            idx   <= '0;
          end else begin
            idx <= idx + ADDR_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          idx   <= '0;
        end
      endcase
    end
  end

  // Read port A with write-through bypass.
  always_comb begin
    ra_data_o = '0;
    ra_busy_o = 1'b0;
    if (idle && (ra_addr_i != '0)) begin
      if (ra_hit_b) begin
        ra_data_o = wb_data_i;
      end else if (ra_hit_a) begin
        ra_data_o = wa_data_i;
      end else begin
        ra_data_o = mem[ra_addr_i];
      end
      ra_busy_o = busy[ra_addr_i] && !(ra_hit_a || ra_hit_b);
    end
  end

  // Read port B with write-through bypass.
  always_comb begin
    rb_data_o = '0;
    rb_busy_o = 1'b0;
    if (idle && (rb_addr_i != '0)) begin
      if (rb_hit_b) begin
        rb_data_o = wb_data_i;
      end else if (rb_hit_a) begin
        rb_data_o = wa_data_i;
      end else begin
        rb_data_o = mem[rb_addr_i];
      end
      rb_busy_o = busy[rb_addr_i] && !(rb_hit_a || rb_hit_b);
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: directed scenarios plus randomized
// traffic compared against an array-based reference model.
module tb_reg_file_mp;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DEPTH  = 32;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              clear_i;
  logic              ready_o;
  logic [ADDR_W-1:0] ra_addr_i, rb_addr_i;
  logic [DATA_W-1:0] ra_data_o, rb_data_o;
  logic              ra_busy_o, rb_busy_o;
  logic              wa_en_i, wb_en_i;
  logic [ADDR_W-1:0] wa_addr_i, wb_addr_i;
  logic [DATA_W-1:0] wa_data_i, wb_data_i;
  logic              issue_en_i;
  logic [ADDR_W-1:0] issue_addr_i;

  int errors = 0;
  int checks = 0;

  // Reference model: register contents, busy flags, cycles of sweep remaining.
  logic [DATA_W-1:0] m_mem  [DEPTH];
  bit                m_busy [DEPTH];
  int                sweep_left = 0;

  reg_file_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .ready_o(ready_o),
    .ra_addr_i(ra_addr_i), .rb_addr_i(rb_addr_i),
    .ra_data_o(ra_data_o), .rb_data_o(rb_data_o),
    .ra_busy_o(ra_busy_o), .rb_busy_o(rb_busy_o),
    .wa_en_i(wa_en_i), .wb_en_i(wb_en_i),
    .wa_addr_i(wa_addr_i), .wb_addr_i(wb_addr_i),
    .wa_data_i(wa_data_i), .wb_data_i(wb_data_i),
    .issue_en_i(issue_en_i), .issue_addr_i(issue_addr_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic bit wr_hit(input logic [ADDR_W-1:0] a, input bit en, input logic [ADDR_W-1:0] wa);
    return en && (wa == a) && (a != 0) && !clear_i && (sweep_left == 0);
  endfunction

  function automatic logic [DATA_W-1:0] exp_data(input logic [ADDR_W-1:0] a);
    if (sweep_left > 0 || a == 0) return '0;
    if (wr_hit(a, wb_en_i, wb_addr_i)) return wb_data_i;
    if (wr_hit(a, wa_en_i, wa_addr_i)) return wa_data_i;
    return m_mem[a];
  endfunction

  function automatic bit exp_busy(input logic [ADDR_W-1:0] a);
    if (sweep_left > 0 || a == 0) return 1'b0;
    if (wr_hit(a, wb_en_i, wb_addr_i) || wr_hit(a, wa_en_i, wa_addr_i)) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
    sweep_left = 0;
  endtask

  // Effect of one rising edge given the inputs currently applied.
  task automatic model_edge();
    if (sweep_left > 0) begin
      sweep_left--;
    end else if (clear_i) begin
      model_reset();
      sweep_left = DEPTH - 1;
    end else begin
      if (wa_en_i && wa_addr_i != 0) begin m_mem[wa_addr_i] = wa_data_i; m_busy[wa_addr_i] = 1'b0; end
      if (wb_en_i && wb_addr_i != 0) begin m_mem[wb_addr_i] = wb_data_i; m_busy[wb_addr_i] = 1'b0; end
      if (issue_en_i && issue_addr_i != 0) m_busy[issue_addr_i] = 1'b1;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    clear_i = 0; wa_en_i = 0; wb_en_i = 0; issue_en_i = 0;
    wa_addr_i = '0; wb_addr_i = '0; issue_addr_i = '0;
    wa_data_i = '0; wb_data_i = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    ra_addr_i = 5'd5; rb_addr_i = 5'd31;
    rst_i = 1'b1;
    model_reset();
    #12;
    checks++;
    if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", ready_o); end
    checks++;
    if (ra_data_o !== '0 || rb_data_o !== '0 || ra_busy_o !== 1'b0 || rb_busy_o !== 1'b0) begin
      errors++; $display("FAIL reset_outputs got ra=%h rb=%h ba=%b bb=%b exp all 0", ra_data_o, rb_data_o, ra_busy_o, rb_busy_o);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    checks++;
    if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_release_ready got=%b exp=1", ready_o); end
  endtask

  task automatic test_basic();
    wa_en_i = 1; wa_addr_i = 5'd5; wa_data_i = 32'h1234_5678;
    tick();
    idle_inputs();
    ra_addr_i = 5'd5;
    #1;
    checks++;
    if (ra_data_o !== 32'h1234_5678) begin errors++; $display("FAIL write_r5 got=%h exp=12345678", ra_data_o); end
    wb_en_i = 1; wb_addr_i = 5'd0; wb_data_i = 32'hFFFF_FFFF;
    rb_addr_i = 5'd0;
    #1;
    checks++;
    if (rb_data_o !== '0) begin errors++; $display("FAIL r0_bypass got=%h exp=0", rb_data_o); end
    tick();
    idle_inputs();
    issue_en_i = 1; issue_addr_i = 5'd0;
    tick();
    idle_inputs();
    #1;
    checks++;
    if (rb_data_o !== '0 || rb_busy_o !== 1'b0) begin
      errors++; $display("FAIL r0_write_issue got data=%h busy=%b exp 0/0", rb_data_o, rb_busy_o);
    end
  endtask

  task automatic test_same_addr();
    wa_en_i = 1; wa_addr_i = 5'd7; wa_data_i = 32'hAAAA_0000;
    wb_en_i = 1; wb_addr_i = 5'd7; wb_data_i = 32'h0000_BBBB;
    ra_addr_i = 5'd7;
    #1;
    checks++;
    if (ra_data_o !== 32'h0000_BBBB) begin errors++; $display("FAIL dual_write_bypass got=%h exp=0000bbbb", ra_data_o); end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (ra_data_o !== 32'h0000_BBBB) begin errors++; $display("FAIL dual_write_stored got=%h exp=0000bbbb", ra_data_o); end
  endtask

  task automatic test_busy();
    rb_addr_i = 5'd9;
    issue_en_i = 1; issue_addr_i = 5'd9;
    tick();
    idle_inputs();
    #1;
    checks++;
    if (rb_busy_o !== 1'b1) begin errors++; $display("FAIL issue_sets_busy got=%b exp=1", rb_busy_o); end
    wa_en_i = 1; wa_addr_i = 5'd9; wa_data_i = 32'h55;
    issue_en_i = 1; issue_addr_i = 5'd9;
    #1;
    checks++;
    if (rb_busy_o !== 1'b0 || rb_data_o !== 32'h55) begin
      errors++; $display("FAIL write_issue_comb got busy=%b data=%h exp 0/55", rb_busy_o, rb_data_o);
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (rb_busy_o !== 1'b1 || rb_data_o !== 32'h55) begin
      errors++; $display("FAIL write_issue_edge got busy=%b data=%h exp 1/55", rb_busy_o, rb_data_o);
    end
    wb_en_i = 1; wb_addr_i = 5'd9; wb_data_i = 32'h66;
    #1;
    checks++;
    if (rb_busy_o !== 1'b0) begin errors++; $display("FAIL lone_write_comb got busy=%b exp=0", rb_busy_o); end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (rb_busy_o !== 1'b0 || rb_data_o !== 32'h66) begin
      errors++; $display("FAIL lone_write_edge got busy=%b data=%h exp 0/66", rb_busy_o, rb_data_o);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      wa_en_i      = 1'($urandom_range(0, 1));
      wb_en_i      = 1'($urandom_range(0, 1));
      issue_en_i   = 1'($urandom_range(0, 1));
      wa_addr_i    = 5'($urandom_range(0, 7));
      wb_addr_i    = 5'($urandom_range(0, 7));
      issue_addr_i = 5'($urandom_range(0, 7));
      ra_addr_i    = 5'($urandom_range(0, 7));
      rb_addr_i    = 5'($urandom_range(0, 7));
      wa_data_i    = $urandom;
      wb_data_i    = $urandom;
      #1;
      checks++;
      if (ra_data_o !== exp_data(ra_addr_i) || ra_busy_o !== exp_busy(ra_addr_i)) begin
        errors++; $display("FAIL rand_port_a cyc=%0d addr=%0d got=%h/%b exp=%h/%b",
                           c, ra_addr_i, ra_data_o, ra_busy_o, exp_data(ra_addr_i), exp_busy(ra_addr_i));
      end
      checks++;
      if (rb_data_o !== exp_data(rb_addr_i) || rb_busy_o !== exp_busy(rb_addr_i)) begin
        errors++; $display("FAIL rand_port_b cyc=%0d addr=%0d got=%h/%b exp=%h/%b",
                           c, rb_addr_i, rb_data_o, rb_busy_o, exp_data(rb_addr_i), exp_busy(rb_addr_i));
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic fill_all();
    for (int i = 1; i < DEPTH; i++) begin
      wa_en_i = 1; wa_addr_i = 5'(i); wa_data_i = 32'h0101_0101 * 32'(i) + 32'h1;
      issue_en_i = 1; issue_addr_i = 5'(i);
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_sweep();
    int n;
    fill_all();
    ra_addr_i = 5'd3;
    #1;
    checks++;
    if (ra_data_o !== m_mem[3] || ra_data_o === '0 || ra_busy_o !== 1'b1) begin
      errors++; $display("FAIL pre_sweep_fill got=%h/%b exp=%h/1", ra_data_o, ra_busy_o, m_mem[3]);
    end
    clear_i = 1;
    tick();
    idle_inputs();
    n = 0;
    while (ready_o !== 1'b1 && n < 100) begin
      wa_en_i = 1; wa_addr_i = 5'd3; wa_data_i = 32'hDEAD_BEEF;
      issue_en_i = 1; issue_addr_i = 5'd4;
      clear_i = 1'(n == 5);
      #1;
      if (ra_data_o !== '0 || ra_busy_o !== 1'b0) begin
        checks++; errors++; $display("FAIL sweep_reads_zero cyc=%0d got=%h/%b exp 0/0", n, ra_data_o, ra_busy_o);
      end
      n++;
      tick();
    end
    idle_inputs();
    checks++;
    if (n !== DEPTH - 1) begin errors++; $display("FAIL sweep_length got=%0d exp=%0d", n, DEPTH - 1); end
    for (int i = 0; i < DEPTH; i++) begin
      ra_addr_i = 5'(i);
      rb_addr_i = 5'(DEPTH - 1 - i);
      #1;
      checks++;
      if (ra_data_o !== '0 || ra_busy_o !== 1'b0 || rb_data_o !== '0 || rb_busy_o !== 1'b0) begin
        errors++; $display("FAIL post_sweep_zero addr=%0d got=%h/%b exp 0/0", i, ra_data_o, ra_busy_o);
      end
    end
    tick();
    checks++;
    if (ready_o !== 1'b1) begin errors++; $display("FAIL post_sweep_idle got=%b exp=1", ready_o); end
  endtask

  task automatic test_reset_mid_sweep();
    fill_all();
    clear_i = 1;
    tick();
    idle_inputs();
    for (int i = 0; i < 10; i++) tick();
    rst_i = 1'b1;
    model_reset();
    #1;
    checks++;
    if (ready_o !== 1'b1) begin errors++; $display("FAIL mid_sweep_reset_ready got=%b exp=1", ready_o); end
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ready_o !== 1'b1) begin
        checks++; errors++; $display("FAIL sweep_resumed cyc=%0d ready=%b exp=1", i, ready_o);
      end
    end
    checks++;
    if (ready_o !== 1'b1) begin errors++; $display("FAIL after_reset_idle got=%b exp=1", ready_o); end
    for (int i = 0; i < DEPTH; i++) begin
      ra_addr_i = 5'(i);
      rb_addr_i = 5'(i);
      #1;
      checks++;
      if (ra_data_o !== '0 || rb_busy_o !== 1'b0) begin
        errors++; $display("FAIL after_reset_zero addr=%0d got=%h/%b exp 0/0", i, ra_data_o, rb_busy_o);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_same_addr();
    test_busy();
    test_random();
    test_sweep();
    test_random();
    test_reset_mid_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
